// File: rtl/clock_ratio_detector_pkg.sv
// Shared types and default constants for the clock ratio detector.
package clock_ratio_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam int          DEFAULT_WIDTH       = 32;
    localparam int          DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned DEFAULT_TIMEOUT     = 32'd1048575;

endpackage

// File: rtl/clock_ratio_detector_edge_synchronizer.sv
// Brings the asynchronous wave into the clock_in domain and flags its
// rising and falling edges, one cycle wide.
module edge_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset,
    input  logic signal_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev;
    logic                   sync;

    assign sync = sync_chain[SYNC_STAGES-1];

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
            prev       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], signal_in};
            prev       <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/clock_ratio_detector.sv
// Measures high/low phase lengths of a slow square wave and recovers the
// divide-by value. Optional glitch rejection: CLOCK_RATIO_GLITCH_FILTER_EN.
module clock_ratio_detector
    import clock_ratio_pkg::*;
#(
    parameter int          WIDTH       = DEFAULT_WIDTH,
    parameter int          SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             signal_in,
    output logic [WIDTH-1:0] high_count,
    output logic [WIDTH-1:0] low_count,
    output logic [WIDTH:0]   period,
    output logic [WIDTH-1:0] divider_est,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] high_next, low_next, phase_len;
    logic             have_high, have_high_next;
    logic             have_low, have_low_next;
    logic             valid_next, locked_next, timeout_next;
    logic             rise, fall, edge_seen, glitch;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == '1) ? v : v + WIDTH'(1);
    endfunction

    edge_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock_in (clock_in),
        .reset    (reset),
        .signal_in(signal_in),
        .rise     (rise),
        .fall     (fall)
    );

    assign edge_seen = rise | fall;
    assign phase_len = sat_inc(cnt);

`ifdef CLOCK_RATIO_GLITCH_FILTER_EN
    assign glitch = (cnt == '0);
`else
    assign glitch = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        cnt_next       = edge_seen ? '0 : sat_inc(cnt);
        high_next      = high_count;
        low_next       = low_count;
        have_high_next = have_high;
        have_low_next  = have_low;
        valid_next     = 1'b0;
        locked_next    = locked;
        timeout_next   = timeout;

        if (!enable) begin
            state_next     = IDLE;
            cnt_next       = '0;
            locked_next    = 1'b0;
            have_high_next = 1'b0;
            have_low_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next    = '0;
                    locked_next = 1'b0;
                    state_next  = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    locked_next = 1'b0;
                    if (edge_seen) begin
                        timeout_next = 1'b0;
                        state_next   = MEASURE;
                    end else if (cnt == TIMEOUT_CNT) begin
                        timeout_next   = 1'b1;
                        have_high_next = 1'b0;
                        have_low_next  = 1'b0;
                    end
                end
                MEASURE: begin
                    // An edge exactly at the threshold still counts as a measurement.
                    if (edge_seen) begin
                        timeout_next = 1'b0;
                        if (glitch) begin
                            have_high_next = 1'b0;
                            have_low_next  = 1'b0;
                            locked_next    = 1'b0;
                            state_next     = WAIT_EDGE;
                        end else begin
                            if (fall) begin
                                high_next      = phase_len;
                                have_high_next = 1'b1;
                            end else begin
                                low_next      = phase_len;
                                have_low_next = 1'b1;
                            end
                            valid_next  = have_high_next & have_low_next;
                            locked_next = have_high_next & have_low_next & (high_next == low_next);
                        end
                    end else if (cnt == TIMEOUT_CNT) begin
                        timeout_next   = 1'b1;
                        locked_next    = 1'b0;
                        have_high_next = 1'b0;
                        have_low_next  = 1'b0;
                        state_next     = WAIT_EDGE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            high_count <= '0;
            low_count  <= '0;
            have_high  <= 1'b0;
            have_low   <= 1'b0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            high_count <= high_next;
            low_count  <= low_next;
            have_high  <= have_high_next;
            have_low   <= have_low_next;
            valid      <= valid_next;
            locked     <= locked_next;
            timeout    <= timeout_next;
        end
    end

    // Zero counts after reset must read back as a zero estimate, not all-ones.
    assign period      = {1'b0, high_count} + {1'b0, low_count};
    assign divider_est = (high_count == '0) ? '0 : high_count - WIDTH'(1);

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Directed bench for clock_ratio_detector with a phase-level reference model
// feeding a scoreboard of expected measurements.
module tb_clock_ratio_detector;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 100;

    logic             clock_in  = 1'b0;
    logic             reset     = 1'b1;
    logic             enable    = 1'b0;
    logic             signal_in = 1'b0;
    logic [WIDTH-1:0] high_count, low_count, divider_est;
    logic [WIDTH:0]   period;
    logic             valid, locked, timeout;

    clock_ratio_detector #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .enable     (enable),
        .signal_in  (signal_in),
        .high_count (high_count),
        .low_count  (low_count),
        .period     (period),
        .divider_est(divider_est),
        .valid      (valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int h;
        int l;
        bit lk;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: current driven level and its length so far.
    bit cur    = 1'b0;
    int curlen = 0;
    bit en_m   = 1'b0;
    bit armed  = 1'b0;
    bit hh     = 1'b0;
    bit hl     = 1'b0;
    int mh     = 0;
    int ml     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void complete_phase();
        if (!en_m) return;
        if (curlen > TIMEOUT + 1) begin
            hh    = 1'b0;
            hl    = 1'b0;
            armed = 1'b1;
        end else if (!armed) begin
            armed = 1'b1;
        end
`ifdef CLOCK_RATIO_GLITCH_FILTER_EN
        else if (curlen == 1) begin
            hh    = 1'b0;
            hl    = 1'b0;
            armed = 1'b0;
        end
`endif
        else begin
            if (cur) begin
                mh = curlen;
                hh = 1'b1;
            end else begin
                ml = curlen;
                hl = 1'b1;
            end
            if (hh && hl) q.push_back('{mh, ml, (mh == ml)});
        end
    endfunction

    task automatic drive(input bit lvl, input int n);
        if (lvl != cur) begin
            complete_phase();
            cur    = lvl;
            curlen = 0;
        end
        signal_in = lvl;
        repeat (n) begin
            @(posedge clock_in);
            #1;
            curlen++;
        end
    endtask

    task automatic model_clear();
        hh    = 1'b0;
        hl    = 1'b0;
        armed = 1'b0;
    endtask

    always @(negedge clock_in) begin : monitor
        exp_t e;
        if (!reset && valid === 1'b1) begin
            chk("valid_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("meas_high", high_count, e.h);
                chk("meas_low", low_count, e.l);
                chk("meas_period", period, e.h + e.l);
                chk("meas_divider_est", divider_est, e.h - 1);
                chk("meas_locked", locked, e.lk);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock_in);
        #1;
        chk("rst_high", high_count, 0);
        chk("rst_low", low_count, 0);
        chk("rst_period", period, 0);
        chk("rst_div", divider_est, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timeout", timeout, 0);
        reset  = 1'b0;
        enable = 1'b1;
        en_m   = 1'b1;

        // Divide-by-3: 4 high / 4 low.
        drive(0, 3);
        for (int i = 0; i < 6; i++) begin
            drive(1, 4);
            drive(0, 4);
        end
        chk("div3_locked", locked, 1);
        chk("div3_high", high_count, 4);
        chk("div3_period", period, 8);
        chk("div3_div", divider_est, 3);

        // Asymmetric 5 high / 9 low.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5);
            drive(0, 9);
        end
        chk("asym_locked", locked, 0);
        chk("asym_high", high_count, 5);
        chk("asym_low", low_count, 9);
        chk("asym_period", period, 14);
        chk("asym_div", divider_est, 4);

        // Phases ending exactly at the timeout threshold are still measured.
        drive(1, TIMEOUT + 1);
        drive(0, TIMEOUT + 1);
        drive(1, 4);
        chk("thresh_timeout", timeout, 0);
        chk("thresh_high", high_count, TIMEOUT + 1);
        chk("thresh_locked", locked, 1);

        // One-cycle high pulse inside a divide-by-3 stream.
        drive(0, 4);
        drive(1, 1);
        drive(0, 4);
        chk("glitch_locked", locked, 0);
`ifdef CLOCK_RATIO_GLITCH_FILTER_EN
        chk("glitch_high", high_count, 4);
`else
        chk("glitch_high", high_count, 1);
`endif
        for (int i = 0; i < 2; i++) begin
            drive(1, 4);
            drive(0, 4);
        end
        chk("glitch_relock", locked, 1);

        // Signal stuck high after lock.
        drive(1, 50);
        chk("stuck_no_timeout_yet", timeout, 0);
        drive(1, 100);
        chk("stuck_timeout", timeout, 1);
        chk("stuck_locked", locked, 0);
        chk("stuck_high_held", high_count, 4);
        chk("stuck_low_held", low_count, 4);
        drive(0, 4);
        chk("stuck_timeout_cleared", timeout, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 4);
            drive(0, 4);
        end
        chk("stuck_relock", locked, 1);

        // Enable dropped mid-stream for 10 cycles.
        drive(1, 3);
        enable = 1'b0;
        en_m   = 1'b0;
        model_clear();
        drive(1, 1);
        chk("dis_valid", valid, 0);
        chk("dis_locked", locked, 0);
        chk("dis_high_held", high_count, mh);
        chk("dis_low_held", low_count, ml);
        drive(0, 4);
        drive(1, 5);
        enable = 1'b1;
        en_m   = 1'b1;
        drive(1, 2);
        drive(0, 4);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4);
            drive(0, 4);
        end
        chk("reen_locked", locked, 1);

        // Reset asserted while a falling edge is being detected.
        drive(1, 4);
        drive(0, 2);
        reset = 1'b1;
        q.delete();
        model_clear();
        mh = 0;
        ml = 0;
        #1;
        chk("midrst_high", high_count, 0);
        chk("midrst_low", low_count, 0);
        chk("midrst_period", period, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_timeout", timeout, 0);
        repeat (2) @(posedge clock_in);
        #1;
        reset = 1'b0;
        drive(0, 3);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4);
            drive(0, 4);
        end
        chk("postrst_locked", locked, 1);

        repeat (8) @(posedge clock_in);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
